pipe_ctrl: RTL

//  Central pipeline sequencer for the IF/ID/EX front end.
//  - Merges redirect requests (EX jump/branch, optional interrupt) and stall requests (EX multi-cycle hold, ID load-use).
//  - Drives pipeline_flush_o into the IF/ID and ID/EX buffers, pc_stall_o into pc_reg and the IF/ID buffer, and a registered redirect (jump_o/jump_addr_o) into pc_reg.
//  - Keeps flush timing in one place: the IF/ID instruction kill is one cycle late, so a flush must cover FLUSH_CYCLES cycles.

---
 rtl/pipe_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: IF/ID/EX pipeline sequencer merging redirect and stall requests.
// Define PIPE_CTRL_IRQ_EN to let an interrupt request act as a redirect source.
module pipe_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_req_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  hold_req_i,
  input  logic                  load_use_i,
  input  logic                  irq_req_i,
  input  logic [ADDR_WIDTH-1:0] irq_vec_i,
  output logic                  irq_ack_o,
  output logic                  jump_o,
  output logic [ADDR_WIDTH-1:0] jump_addr_o,
  output logic                  pipeline_flush_o,
  output logic                  pc_stall_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  logic [1:0]            state, state_nxt;
  logic [3:0]            fcnt, fcnt_nxt;
  logic                  irq_accept;
  logic                  redirect;
  logic                  flush_nxt;
  logic [ADDR_WIDTH-1:0] target;

`ifdef PIPE_CTRL_IRQ_EN
  // An interrupt only gets in on a completely quiet RUN cycle.
  assign irq_accept = (state == ST_RUN) & irq_req_i & ~jump_req_i & ~hold_req_i & ~load_use_i;
  assign target     = jump_req_i ? jump_addr_i : irq_vec_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_ack_o <= 1'b0;
    else        irq_ack_o <= irq_accept;
  end
`else
  logic unused_irq;
  assign unused_irq = ^{irq_req_i, irq_vec_i};
  assign irq_accept = 1'b0;
  assign target     = jump_addr_i;
  assign irq_ack_o  = 1'b0;
`endif

  assign redirect = jump_req_i | irq_accept;

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    if (redirect) begin
      state_nxt = ST_FLUSH;
      fcnt_nxt  = FLUSH_INIT;
    end else begin
      case (state)
        ST_FLUSH: begin
          if (fcnt != 4'd0) fcnt_nxt  = fcnt - 4'd1;
          else              state_nxt = hold_req_i ? ST_HOLD : ST_RUN;
        end
        ST_RUN:  if (hold_req_i)  state_nxt = ST_HOLD;
        ST_HOLD: if (!hold_req_i) state_nxt = ST_RUN;
        default: state_nxt = ST_RUN;
      endcase
    end
    flush_nxt = redirect | ((state == ST_FLUSH) && (fcnt != 4'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_RUN;
      fcnt             <= 4'd0;
      jump_o           <= 1'b0;
      jump_addr_o      <= '0;
      pipeline_flush_o <= 1'b0;
    end else begin
      state            <= state_nxt;
      fcnt             <= fcnt_nxt;
      jump_o           <= redirect;
      pipeline_flush_o <= flush_nxt;
      if (redirect) jump_addr_o <= target;
    end
  end

  // A same-cycle jump wins over any stall; the flush window never stalls.
  assign pc_stall_o = rst_n & ~jump_req_i &
                      (((state == ST_HOLD) & hold_req_i) |
                       ((state == ST_RUN) & (hold_req_i | load_use_i)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_o <= '0;
    else if (pc_stall_o && (stall_cnt_o != {CNT_WIDTH{1'b1}}))
      stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
  end

endmodule
